ring_fifo_p: RTL and testbench
==============================

# ring_fifo_p

Parametrised ring-buffer FIFO: next generation of the shift-register/ring-buffer FIFO pair used in the FIFO equivalence models. It generalises width and depth, including non-power-of-two depths. It executes push and pop in the same cycle, exposes an occupancy count, almost-full/almost-empty thresholds and sticky overflow/underflow flags, and offers an overwrite-oldest mode. It is intended both as a reusable buffer and as the DUT in the next round of equivalence and property-checking models.

## Interface
- WIDTH, 4: data width in bits, ≥1.
- DEPTH, 5: number of entries, ≥2, any integer.
- AE_LEVEL, 1: almost_empty asserts when count ≤ AE_LEVEL; 0 ≤ AE_LEVEL < DEPTH.
- AF_LEVEL, 4: almost_full asserts when count ≥ AF_LEVEL; 0 < AF_LEVEL ≤ DEPTH.
- OVERWRITE, 0: 0 = drop a push on full; 1 = a push on full overwrites the oldest entry.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dataIn  in  WIDTH  write data.
- push  in  1  write request.
- pop  in  1  read request.
- clear_err  in  1  synchronous clear of overflow and underflow.
- dataOut  out  WIDTH  oldest entry (first-word fall-through); 0 when empty.
- count  out  CW = clog2(DEPTH+1)  number of entries held.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- overflow  out  1  sticky: a push found the FIFO full with no pop in the same cycle.
- underflow  out  1  sticky: a pop found the FIFO empty.

## Operation
- State: mem[0:DEPTH-1], head (write index), tail (read index), count, overflow, underflow. Pointer width AW = clog2(DEPTH).
- Pointer increment: the pointer wraps to 0 when it equals DEPTH-1. There is no binary wrap; non-power-of-two depths must wrap correctly.
- Per cycle, with wr = push and rd = pop:
  - Not empty, not full, rd and wr: write at head, advance head, advance tail, count unchanged.
  - Empty, wr: write at head, advance head, count becomes 1.
  - Empty, rd: pop is a no-op and sets underflow. This applies even when wr is also asserted; the push still executes.
  - Full, wr and rd: both operations execute, count stays DEPTH, overflow is not set.
  - Full, wr only, OVERWRITE=0: no state change, sets overflow.
  - Full, wr only, OVERWRITE=1: write at head, advance head and tail, count stays DEPTH, sets overflow.
  - Only rd, not empty: advance tail, count decrements.
- clear_err clears both flags. If a new error occurs in the same cycle as clear_err, the flag is set (set wins).
- Status outputs and dataOut are combinational decodes of registered state. No input reaches an output combinationally.
- Invariants (provable): count ≤ DEPTH; (head − tail) mod DEPTH == count mod DEPTH.

## Timing
- Reset (reset_n low, asynchronous): head = tail = count = 0, overflow = underflow = 0. The memory contents are not reset.
- Output values in reset: empty = 1, full = 0, almost_empty = 1, almost_full = 0, dataOut = 0.
- Release of reset_n is synchronous to clock. The first operation is accepted on the first rising edge with reset_n high.
- Write latency: data pushed at edge N is visible on dataOut after edge N when the FIFO was empty. Status flags update after the same edge.
- Reset asserted mid-operation empties the FIFO immediately. Any in-flight push or pop in that cycle is discarded.

## Structure
- Shared package fifo_pkg holds:
  - a clog2 function;
  - mode constants FIFO_DROP = 0 and FIFO_OVERWRITE = 1;
  - a parameter-legality check macro or function covering the DEPTH, AE_LEVEL and AF_LEVEL ranges.
- One sub-module, ring_ptr: a parametrised modulo-DEPTH pointer register with an advance input, async active-low reset, and a value output. It is instantiated twice (head, tail).
- Memory is a plain register array inside ring_fifo_p.

## Test plan
- Reset, then push 1,2,3 (DEPTH=5) → dataOut = 1, count = 3. Pop ×3 → outputs 1,2,3, then empty = 1, dataOut = 0.
- Fill DEPTH=5, then push 9 with OVERWRITE=0 → count stays 5, dataOut unchanged, overflow = 1. Assert clear_err → overflow = 0.
- Same sequence with OVERWRITE=1 (contents 1..5, push 9) → dataOut = 2, count = 5, pop order 2,3,4,5,9, overflow = 1.
- Simultaneous push/pop: at count 3, count stays 3 for 10 cycles with in-order data. At full, count stays 5 and no overflow. At empty, underflow = 1 and count becomes 1.
- Wrap-around with DEPTH=5: 12 push/pop pairs → head and tail pass 4→0 repeatedly; data order and count are preserved.
- reset_n pulsed low mid-burst at count 4 → all outputs take their reset values immediately. Equivalence check against a DEPTH=5 shift-register reference model with OVERWRITE=0 → data and flags agree whenever not empty.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the ring FIFO family: clog2, overwrite-mode constants
// and a parameter legality check.
package fifo_pkg;

  localparam int FIFO_DROP      = 0;
  localparam int FIFO_OVERWRITE = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit fifo_params_ok(input int width, input int depth,
                                        input int ae_level, input int af_level);
    return (width >= 1) && (depth >= 2) &&
           (ae_level >= 0) && (ae_level < depth) &&
           (af_level > 0) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/ring_fifo_p_if.sv
// Request/status bundle of ring_fifo_p; master drives requests, slave is the FIFO.
interface ring_fifo_p_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 5
);
  import fifo_pkg::*;

  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] dataIn;
  logic             push;
  logic             pop;
  logic             clear_err;
  logic [WIDTH-1:0] dataOut;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output dataIn, push, pop, clear_err,
    input  dataOut, count, full, empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  dataIn, push, pop, clear_err,
    output dataOut, count, full, empty, almost_full, almost_empty, overflow, underflow
  );

endinterface

// File: rtl/ring_ptr.sv
// Modulo-DEPTH pointer register: advances by one, wraps from DEPTH-1 to 0.
module ring_ptr #(
  parameter int DEPTH = 5,
  parameter int AW    = 3
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          advance,
  output logic [AW-1:0] value
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else if (advance) begin
      value <= (value == AW'(DEPTH - 1)) ? '0 : value + AW'(1);
    end
  end

endmodule

// File: rtl/ring_fifo_p.sv
// Ring-buffer FIFO with any depth, same-cycle push/pop, thresholds, sticky
// error flags and optional overwrite-oldest on full; outputs decode registered state.
module ring_fifo_p
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 5,
  parameter int AE_LEVEL  = 1,
  parameter int AF_LEVEL  = 4,
  parameter int OVERWRITE = FIFO_DROP
) (
  input  logic         clock,
  input  logic         reset_n,
  ring_fifo_p_if.slave bus
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  if (!fifo_params_ok(WIDTH, DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_bad_params
    $error("ring_fifo_p: illegal WIDTH/DEPTH/AE_LEVEL/AF_LEVEL combination");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_nxt;
  logic             overflow_q;
  logic             underflow_q;
  logic             is_full;
  logic             is_empty;
  logic             do_wr;
  logic             adv_tail;
  logic             set_ovf;
  logic             set_udf;

  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);

  always_comb begin
    do_wr     = 1'b0;
    adv_tail  = 1'b0;
    set_ovf   = 1'b0;
    set_udf   = 1'b0;
    count_nxt = count_q;

    set_udf = bus.pop && is_empty;
    set_ovf = bus.push && !bus.pop && is_full;

    // A push into a full FIFO lands only if a pop frees a slot this cycle
    // or overwrite mode evicts the oldest entry by advancing tail with it.
    do_wr    = bus.push && (!is_full || bus.pop || (OVERWRITE == FIFO_OVERWRITE));
    adv_tail = (bus.pop && !is_empty) ||
               (set_ovf && (OVERWRITE == FIFO_OVERWRITE));

    if (do_wr && !adv_tail) begin
      count_nxt = count_q + CW'(1);
    end else if (adv_tail && !do_wr) begin
      count_nxt = count_q - CW'(1);
    end
  end

  ring_ptr #(.DEPTH(DEPTH), .AW(AW)) u_head (
    .clock   (clock),
    .reset_n (reset_n),
    .advance (do_wr),
    .value   (head)
  );

  ring_ptr #(.DEPTH(DEPTH), .AW(AW)) u_tail (
    .clock   (clock),
    .reset_n (reset_n),
    .advance (adv_tail),
    .value   (tail)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_nxt;
      overflow_q  <= set_ovf || (overflow_q && !bus.clear_err);
      underflow_q <= set_udf || (underflow_q && !bus.clear_err);
    end
  end

  // Storage is not reset; count alone decides what is valid.
  always_ff @(posedge clock) begin
    if (reset_n && do_wr) begin
      mem[head] <= bus.dataIn;
    end
  end

  assign bus.dataOut      = is_empty ? '0 : mem[tail];
  assign bus.count        = count_q;
  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_ring_fifo_p.sv
// Directed bench for ring_fifo_p (DEPTH=5) in drop and overwrite modes,
// cross-checked every cycle against a queue-based reference.
module tb_ring_fifo_p;
  import fifo_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  ring_fifo_p_if #(.WIDTH(4), .DEPTH(5)) b0 ();
  ring_fifo_p_if #(.WIDTH(4), .DEPTH(5)) b1 ();

  ring_fifo_p #(.WIDTH(4), .DEPTH(5), .AE_LEVEL(1), .AF_LEVEL(4), .OVERWRITE(FIFO_DROP)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(b0));
  ring_fifo_p #(.WIDTH(4), .DEPTH(5), .AE_LEVEL(1), .AF_LEVEL(4), .OVERWRITE(FIFO_OVERWRITE)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(b1));

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  logic o0 = 1'b0, u0 = 1'b0, o1 = 1'b0, u1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete();
    o0 = 1'b0; u0 = 1'b0; o1 = 1'b0; u1 = 1'b0;
  endtask

  task automatic model_chk();
    logic [3:0] tq[$];
    logic to, tu;
    logic [31:0] od, oc;
    logic of, oe, oaf, oae, oo, ou;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        tq = q0; to = o0; tu = u0;
        od = 32'(b0.dataOut); oc = 32'(b0.count); of = b0.full; oe = b0.empty;
        oaf = b0.almost_full; oae = b0.almost_empty; oo = b0.overflow; ou = b0.underflow;
      end else begin
        tq = q1; to = o1; tu = u1;
        od = 32'(b1.dataOut); oc = 32'(b1.count); of = b1.full; oe = b1.empty;
        oaf = b1.almost_full; oae = b1.almost_empty; oo = b1.overflow; ou = b1.underflow;
      end
      chk($sformatf("dut%0d.dataOut", k), od, (tq.size() != 0) ? 32'(tq[0]) : 32'd0);
      chk($sformatf("dut%0d.count", k), oc, 32'(tq.size()));
      chk($sformatf("dut%0d.full", k), 32'(of), 32'(tq.size() == 5));
      chk($sformatf("dut%0d.empty", k), 32'(oe), 32'(tq.size() == 0));
      chk($sformatf("dut%0d.almost_full", k), 32'(oaf), 32'(tq.size() >= 4));
      chk($sformatf("dut%0d.almost_empty", k), 32'(oae), 32'(tq.size() <= 1));
      chk($sformatf("dut%0d.overflow", k), 32'(oo), 32'(to));
      chk($sformatf("dut%0d.underflow", k), 32'(ou), 32'(tu));
    end
  endtask

  // One clock with the given request on both FIFOs; reference updated from pre-edge state.
  task automatic step(input logic p, input logic r, input logic [3:0] d, input logic c);
    logic [3:0] tq[$];
    logic to, tu, so, su;
    int n;
    b0.push = p; b0.pop = r; b0.dataIn = d; b0.clear_err = c;
    b1.push = p; b1.pop = r; b1.dataIn = d; b1.clear_err = c;
    @(posedge clock);
    if (reset_n) begin
      for (int k = 0; k < 2; k++) begin
        if (k == 0) begin tq = q0; to = o0; tu = u0; end
        else        begin tq = q1; to = o1; tu = u1; end
        n  = tq.size();
        so = p && !r && (n == 5);
        su = r && (n == 0);
        if (r && n != 0) void'(tq.pop_front());
        if (p && (n != 5 || r)) tq.push_back(d);
        else if (p && k == 1) begin
          void'(tq.pop_front());
          tq.push_back(d);
        end
        to = so | (to & !c);
        tu = su | (tu & !c);
        if (k == 0) begin q0 = tq; o0 = to; u0 = tu; end
        else        begin q1 = tq; o1 = to; u1 = tu; end
      end
    end
    #1;
    model_chk();
  endtask

  initial begin
    logic [3:0] e0[5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    logic [3:0] e1[5] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd9};
    logic p, r, c;

    b0.push = 0; b0.pop = 0; b0.dataIn = 0; b0.clear_err = 0;
    b1.push = 0; b1.pop = 0; b1.dataIn = 0; b1.clear_err = 0;

    // Reset values
    #1 reset_n = 1'b0;
    #2;
    chk("rst.empty", 32'(b0.empty), 32'd1);
    chk("rst.full", 32'(b0.full), 32'd0);
    chk("rst.almost_empty", 32'(b0.almost_empty), 32'd1);
    chk("rst.almost_full", 32'(b0.almost_full), 32'd0);
    chk("rst.dataOut", 32'(b0.dataOut), 32'd0);
    chk("rst.count", 32'(b0.count), 32'd0);
    chk("rst.overflow", 32'(b0.overflow), 32'd0);
    chk("rst.underflow", 32'(b0.underflow), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;

    // Basic push/pop and first-word fall-through
    step(1, 0, 4'd1, 0);
    chk("fwft.dataOut", 32'(b0.dataOut), 32'd1);
    chk("fwft.almost_empty1", 32'(b0.almost_empty), 32'd1);
    step(1, 0, 4'd2, 0);
    chk("fwft.almost_empty2", 32'(b0.almost_empty), 32'd0);
    step(1, 0, 4'd3, 0);
    chk("p3.dataOut", 32'(b0.dataOut), 32'd1);
    chk("p3.count", 32'(b0.count), 32'd3);
    step(0, 1, 4'd0, 0);
    chk("pop1.dataOut", 32'(b0.dataOut), 32'd2);
    step(0, 1, 4'd0, 0);
    chk("pop2.dataOut", 32'(b0.dataOut), 32'd3);
    step(0, 1, 4'd0, 0);
    chk("pop3.empty", 32'(b0.empty), 32'd1);
    chk("pop3.dataOut", 32'(b0.dataOut), 32'd0);

    // Full + push: drop vs overwrite
    for (int i = 1; i <= 5; i++) step(1, 0, 4'(i), 0);
    chk("fill.full", 32'(b0.full), 32'd1);
    chk("fill.almost_full", 32'(b0.almost_full), 32'd1);
    step(1, 0, 4'd9, 0);
    chk("drop.count", 32'(b0.count), 32'd5);
    chk("drop.dataOut", 32'(b0.dataOut), 32'd1);
    chk("drop.overflow", 32'(b0.overflow), 32'd1);
    chk("ow.count", 32'(b1.count), 32'd5);
    chk("ow.dataOut", 32'(b1.dataOut), 32'd2);
    chk("ow.overflow", 32'(b1.overflow), 32'd1);
    step(0, 0, 4'd0, 1);
    chk("clr.overflow0", 32'(b0.overflow), 32'd0);
    chk("clr.overflow1", 32'(b1.overflow), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("drain.drop%0d", i), 32'(b0.dataOut), 32'(e0[i]));
      chk($sformatf("drain.ow%0d", i), 32'(b1.dataOut), 32'(e1[i]));
      step(0, 1, 4'd0, 0);
    end
    chk("drain.empty0", 32'(b0.empty), 32'd1);
    chk("drain.empty1", 32'(b1.empty), 32'd1);

    // Simultaneous push/pop at count 3, at full, at empty
    for (int i = 1; i <= 3; i++) step(1, 0, 4'(i), 0);
    for (int k = 0; k < 10; k++) begin
      step(1, 1, 4'(4 + k), 0);
      chk($sformatf("pp3.count%0d", k), 32'(b0.count), 32'd3);
      chk($sformatf("pp3.data%0d", k), 32'(b0.dataOut), 32'(k + 2));
    end
    step(1, 0, 4'd14, 0);
    step(1, 0, 4'd15, 0);
    step(1, 1, 4'd0, 0);
    chk("ppfull.count", 32'(b0.count), 32'd5);
    chk("ppfull.overflow", 32'(b0.overflow), 32'd0);
    chk("ppfull.overflow_ow", 32'(b1.overflow), 32'd0);
    chk("ppfull.dataOut", 32'(b0.dataOut), 32'd12);
    repeat (5) step(0, 1, 4'd0, 0);
    step(1, 1, 4'd7, 0);
    chk("ppempty.underflow", 32'(b0.underflow), 32'd1);
    chk("ppempty.count", 32'(b0.count), 32'd1);
    chk("ppempty.dataOut", 32'(b0.dataOut), 32'd7);
    step(0, 1, 4'd0, 0);
    step(0, 1, 4'd0, 1);
    chk("setwins.underflow", 32'(b0.underflow), 32'd1);
    step(0, 0, 4'd0, 1);
    chk("clr.underflow", 32'(b0.underflow), 32'd0);

    // Wrap-around: 12 push/pop pairs at count 1
    step(1, 0, 4'd1, 0);
    for (int k = 0; k < 12; k++) begin
      step(1, 1, 4'(k + 2), 0);
      chk($sformatf("wrap.data%0d", k), 32'(b0.dataOut), 32'(k + 2));
      chk($sformatf("wrap.count%0d", k), 32'(b0.count), 32'd1);
    end

    // Reset mid-burst at count 4
    step(0, 1, 4'd0, 0);
    for (int i = 1; i <= 4; i++) step(1, 0, 4'(i), 0);
    chk("midrst.pre_count", 32'(b0.count), 32'd4);
    b0.push = 1; b0.dataIn = 4'd5; b1.push = 1; b1.dataIn = 4'd5;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("midrst.count", 32'(b0.count), 32'd0);
    chk("midrst.empty", 32'(b0.empty), 32'd1);
    chk("midrst.full", 32'(b0.full), 32'd0);
    chk("midrst.almost_full", 32'(b0.almost_full), 32'd0);
    chk("midrst.dataOut", 32'(b0.dataOut), 32'd0);
    chk("midrst.count_ow", 32'(b1.count), 32'd0);
    model_chk();
    @(posedge clock);
    #1;
    chk("midrst.push_discarded", 32'(b0.count), 32'd0);
    model_chk();
    @(negedge clock);
    b0.push = 0; b1.push = 0;
    reset_n = 1'b1;

    // Mixed traffic checked cycle by cycle against the reference
    for (int i = 0; i < 120; i++) begin
      p = (i < 60) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 30);
      r = (i < 60) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 70);
      c = ($urandom_range(0, 15) == 0);
      step(p, r, 4'($urandom_range(0, 15)), c);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
